parity_accum: RTL and testbench
===============================

PARITY_ACCUM -- requirements
Module: parity_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of data bits per frame (2..32).
REQ-002 SHALL have parameter ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 RESET_N  input  1  asynchronous active-low reset.
REQ-006 START  input  1  begin new frame; mode sampled with it.
REQ-007 CHECK  input  1  sampled with START; 1 = check mode, frame is WIDTH data bits plus 1 received parity bit.
REQ-008 BIT_VALID  input  1  BIT_IN is valid this cycle.
REQ-009 BIT_IN  input  1  serial data bit.
REQ-010 BUSY  output  1  high in ACCUM.
REQ-011 BIT_COUNT  output  $clog2(WIDTH+2)  bits accepted in current frame.
REQ-012 PARITY_VALID  output  1  result available; high only in HOLD.
REQ-013 PARITY_OUT  output  1  generated parity bit (generate mode) or raw accumulator (check mode).
REQ-014 MISMATCH  output  1  check mode only: received parity wrong; 0 in generate mode.
REQ-015 PARITY_READY  input  1  consumer accepts result.

Function
REQ-016 SHALL implement states IDLE, ACCUM, HOLD.
REQ-017 IDLE: START=1 -> ACCUM; accumulator loaded with ODD, BIT_COUNT cleared to 0, CHECK latched.
REQ-018 ACCUM: each cycle with BIT_VALID=1, accumulator <= accumulator XOR BIT_IN, BIT_COUNT increments by 1.
REQ-019 Frame length SHALL be WIDTH (generate) or WIDTH+1 (check); accepting the last bit moves to HOLD on that edge, so PARITY_VALID rises the cycle after the last bit is sampled (latency 1).
REQ-020 HOLD: PARITY_OUT = accumulator; MISMATCH = latched CHECK AND accumulator; all outputs stable until PARITY_READY=1.
REQ-021 HOLD with PARITY_READY=1 and START=0 -> IDLE next cycle.
REQ-022 HOLD with PARITY_READY=1 and START=1 -> handshake completes and new frame starts (ACCUM) same edge, no IDLE cycle.
REQ-023 HOLD with START=1 and PARITY_READY=0: START ignored.
REQ-024 ACCUM with START=1: current frame aborted, restarted per REQ-017; BIT_VALID that cycle ignored.
REQ-025 IDLE with START and BIT_VALID same cycle: bit ignored; first data bit counted is the next one.
REQ-026 BIT_VALID in IDLE or HOLD SHALL be ignored (no state change).
REQ-027 BIT_COUNT SHALL never exceed WIDTH+1; no wrap.
REQ-028 PARITY_OUT, MISMATCH SHALL read 0 outside HOLD.

Reset
REQ-029 RESET_N=0 SHALL force IDLE immediately, regardless of clock.
REQ-030 Reset values: BUSY=0, BIT_COUNT=0, PARITY_VALID=0, PARITY_OUT=0, MISMATCH=0, accumulator=0, latched CHECK=0.
REQ-031 Reset mid-frame or in HOLD SHALL discard the frame; no result presented after release.
REQ-032 First START SHALL be honoured on the first rising edge after RESET_N deasserts.

Structure
REQ-033 Shared package parity_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD) and default WIDTH constant.
REQ-034 Accumulate XOR SHALL be an instance of the team's existing xor2 gate (Y = X1 XOR X2); no other sub-module.
REQ-035 Implementation SHALL be synthesizable, single always block for state/registers plus combinational output logic.

Verification
REQ-036 Generate, even: START, CHECK=0, bits 1,0,1,1,0,0,1,0 back-to-back -> PARITY_VALID one cycle after 8th bit, PARITY_OUT=0, MISMATCH=0.
REQ-037 Generate, ODD=1: same bits with BIT_VALID gaps -> PARITY_OUT=1; BIT_COUNT steps 0..8 only on valid cycles.
REQ-038 Check: START, CHECK=1, data 1,1,1,0,0,0,0,0 then parity bit 0 -> MISMATCH=1; repeat with parity 1 -> MISMATCH=0.
REQ-039 Backpressure: hold PARITY_READY=0 five cycles, toggle BIT_IN/START -> outputs unchanged; READY with START same cycle -> BUSY=1 next cycle, BIT_COUNT=0.
REQ-040 Abort/reset: START after 4 bits -> BIT_COUNT=0, result reflects only new 8 bits; RESET_N low mid-frame between edges -> IDLE, all outputs 0 immediately.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity accumulator.
package parity_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Bits in a frame: data only when generating, data plus received parity when checking.
  function automatic int unsigned frame_len(input int unsigned width, input logic check);
    return width + (check ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/xor2.sv
// Two-input XOR gate cell.
module xor2 (
  input  logic X1,
  input  logic X2,
  output logic Y
);

  assign Y = X1 ^ X2;

endmodule

// File: rtl/parity_accum.sv
// Serial even/odd parity generator and checker with a hold-until-ready result handshake.
module parity_accum
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter bit          ODD   = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        check_i,
  input  logic                        bit_valid_i,
  input  logic                        bit_i,
  input  logic                        parity_ready_i,
  output logic                        busy_o,
  output logic [$clog2(WIDTH+2)-1:0]  bit_count_o,
  output logic                        parity_valid_o,
  output logic                        parity_out_o,
  output logic                        mismatch_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);

  state_e             state_q, state_d;
  logic               acc_q, acc_d;
  logic               chk_q, chk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               par_q, par_d;
  logic               mis_q, mis_d;
  logic               acc_xor;
  logic               restart;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   last_cnt;

  xor2 u_acc_xor (
    .X1 (acc_q),
    .X2 (bit_i),
    .Y  (acc_xor)
  );

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign last_cnt = CNT_W'(frame_len(WIDTH, chk_q));

  // Next state, accumulator and registered-output values.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    restart = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) restart = 1'b1;
      end
      ACCUM: begin
        if (start_i) begin
          restart = 1'b1;
        end else if (bit_valid_i) begin
          acc_d = acc_xor;
          cnt_d = cnt_inc;
          if (cnt_inc == last_cnt) state_d = HOLD;
        end
      end
      HOLD: begin
        if (parity_ready_i) begin
          if (start_i) restart = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start (new, aborting, or back-to-back after handshake) reloads the frame.
    if (restart) begin
      state_d = ACCUM;
      acc_d   = ODD;
      cnt_d   = '0;
      chk_d   = check_i;
    end

    busy_d  = (state_d == ACCUM);
    valid_d = (state_d == HOLD);
    par_d   = (state_d == HOLD) ? acc_d : 1'b0;
    mis_d   = (state_d == HOLD) ? (chk_d & acc_d) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      chk_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      par_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      par_q   <= par_d;
      mis_q   <= mis_d;
    end
  end

  assign busy_o         = busy_q;
  assign bit_count_o    = cnt_q;
  assign parity_valid_o = valid_q;
  assign parity_out_o   = par_q;
  assign mismatch_o     = mis_q;

endmodule

// File: tb/tb_parity_accum.sv
// Directed bench for parity_accum: an even and an odd instance driven by the same stimulus.
module tb_parity_accum;
  import parity_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned CW  = $clog2(W + 2);

  logic clk = 1'b0;
  logic rst_n;
  logic start, check, bv, bin, ready;

  logic          busy_e, valid_e, par_e, mis_e;
  logic          busy_o1, valid_o1, par_o1, mis_o1;
  logic [CW-1:0] cnt_e, cnt_o1;

  int n_vec = 0;
  int n_err = 0;

  parity_accum #(.WIDTH(W), .ODD(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .start_i(start), .check_i(check),
    .bit_valid_i(bv), .bit_i(bin), .parity_ready_i(ready),
    .busy_o(busy_e), .bit_count_o(cnt_e), .parity_valid_o(valid_e),
    .parity_out_o(par_e), .mismatch_o(mis_e)
  );

  parity_accum #(.WIDTH(W), .ODD(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .start_i(start), .check_i(check),
    .bit_valid_i(bv), .bit_i(bin), .parity_ready_i(ready),
    .busy_o(busy_o1), .bit_count_o(cnt_o1), .parity_valid_o(valid_o1),
    .parity_out_o(par_o1), .mismatch_o(mis_o1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sit 1ns past the edge.
  task automatic step(input logic s, input logic c, input logic v, input logic b, input logic r);
    start = s; check = c; bv = v; bin = b; ready = r;
    @(posedge clk);
    #1;
  endtask

  // Even/odd instance status in one go.
  task automatic chk_all(input string tag, input int busy, input int cnt, input int valid,
                         input int pe, input int po, input int me, input int mo);
    chk({tag, ".busy_e"},  32'(busy_e),  busy);
    chk({tag, ".busy_o"},  32'(busy_o1), busy);
    chk({tag, ".cnt_e"},   32'(cnt_e),   cnt);
    chk({tag, ".cnt_o"},   32'(cnt_o1),  cnt);
    chk({tag, ".valid_e"}, 32'(valid_e), valid);
    chk({tag, ".valid_o"}, 32'(valid_o1), valid);
    chk({tag, ".par_e"},   32'(par_e),   pe);
    chk({tag, ".par_o"},   32'(par_o1),  po);
    chk({tag, ".mis_e"},   32'(mis_e),   me);
    chk({tag, ".mis_o"},   32'(mis_o1),  mo);
  endtask

  logic [7:0] gen_bits;
  logic [7:0] chk_bits;
  logic [7:0] zero_one;

  initial begin
    gen_bits = 8'b0100_1101;  // sent LSB first: 1,0,1,1,0,0,1,0
    chk_bits = 8'b0000_0111;  // 1,1,1,0,0,0,0,0
    zero_one = 8'b1000_0000;  // 0,0,0,0,0,0,0,1
    rst_n = 1'b0;
    start = 0; check = 0; bv = 0; bin = 0; ready = 0;

    // Reset state
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Generate mode, back-to-back bits
    step(1, 0, 0, 0, 0);
    chk_all("gen.start", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, gen_bits[i], 0);
    chk_all("gen.bit7", 1, 7, 0, 0, 0, 0, 0);
    step(0, 0, 1, gen_bits[7], 0);
    chk_all("gen.done", 0, 8, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    chk_all("gen.idle", 0, 8, 0, 0, 0, 0, 0);

    // Generate mode with gaps; count moves only on valid cycles
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, gen_bits[i], 0);
      chk("gap.cnt_valid", 32'(cnt_o1), i + 1);
      if (i < 7) begin
        step(0, 0, 0, ~gen_bits[i], 0);
        chk("gap.cnt_hold", 32'(cnt_o1), i + 1);
      end
    end
    chk_all("gap.done", 0, 8, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);

    // Check mode, wrong received parity (even instance) then correct
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, chk_bits[i], 0);
    chk_all("chk0.data", 1, 8, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1'b0, 0);
    chk_all("chk0.done", 0, 9, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, chk_bits[i], 0);
    step(0, 0, 1, 1'b1, 0);
    chk_all("chk1.done", 0, 9, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_all("chk1.idle", 0, 9, 0, 0, 0, 0, 0);

    // Backpressure: HOLD ignores bits and start until ready
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, gen_bits[i], 0);
    for (int i = 0; i < 5; i++) begin
      step(logic'(i % 2), 1, 1, logic'((i + 1) % 2), 0);
      chk_all("bp.hold", 0, 8, 1, 0, 1, 0, 0);
    end
    step(1, 0, 1, 1, 1);
    chk_all("bp.restart", 1, 0, 0, 0, 0, 0, 0);

    // Abort after four bits; only the new frame counts
    for (int i = 0; i < 4; i++) step(0, 0, 1, chk_bits[i], 0);
    chk("abort.cnt4", 32'(cnt_e), 4);
    step(1, 0, 1, 1, 0);
    chk_all("abort.start", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, zero_one[i], 0);
    chk_all("abort.done", 0, 8, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // Start with a valid bit in IDLE: bit not counted
    step(1, 0, 1, 1, 0);
    chk_all("idle.startbit", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    chk("idle.cnt3", 32'(cnt_e), 3);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("arst.now", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 1, 1, 1);
    chk_all("arst.after", 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk_all("arst.start", 1, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
